// File: rtl/amstrad_ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package amstrad_ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  localparam logic [7:0] CODE_E0 = 8'hE0;
  localparam logic [7:0] CODE_F0 = 8'hF0;
  localparam logic [7:0] CODE_E1 = 8'hE1;

  // Keyboard status/reply bytes that never represent a key on their own.
  localparam int unsigned NUM_NON_KEY = 8;
  localparam logic [7:0] NON_KEY_CODES [NUM_NON_KEY] = '{
    8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF
  };

  function automatic logic is_non_key(input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int unsigned i = 0; i < NUM_NON_KEY; i++) begin
      if (NON_KEY_CODES[i] == code) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/ps2_key_rx_if.sv
// Key event bus produced by the PS/2 receiver.
interface ps2_key_rx_if;
  logic       key_strobe;
  logic       key_pressed;
  logic       key_extended;
  logic [7:0] key_code;
  logic       rx_error;

  modport master (
    output key_strobe, key_pressed, key_extended, key_code, rx_error
  );

  modport slave (
    input key_strobe, key_pressed, key_extended, key_code, rx_error
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser followed by a run-length glitch filter.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic line_i,
  output logic line_o
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Bring the asynchronous line into the clk domain.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= line_i;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt    <= '0;
      line_o <= 1'b1;
    end else if (sync2 == line_o) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt    <= '0;
      line_o <= sync2;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ps2_key_rx.sv
// PS/2 set-2 keyboard receiver: frame capture plus make/break/prefix decode.
module ps2_key_rx
  import amstrad_ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 40000
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  ps2_key_rx_if.master key
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic          fclk, fdata, fclk_q, fall;
  rx_state_t     state, state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          timeout, par_ok;
  logic          start_en, shift_en, par_en, byte_done, frame_err;
  logic          valid_q, err_q;
  logic [7:0]    byte_q;
  logic          ext, brk;
  logic [2:0]    skip;
  logic          strobe_r, error_r, pressed_r, extended_r;
  logic [7:0]    code_r;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset_n(reset_n), .line_i(ps2_clk_i), .line_o(fclk)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(clk), .reset_n(reset_n), .line_i(ps2_data_i), .line_o(fdata)
  );

  // Previous filtered clock, for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset_n) fclk_q <= 1'b1;
    else          fclk_q <= fclk;
  end

  assign fall    = fclk_q & ~fclk;
  assign timeout = (state != ST_IDLE) && (tmo_cnt == TMO_LAST);
  assign par_ok  = ^{shreg, par_bit};

  // Frame state register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; a timeout overrides any edge in the same cycle.
  always_comb begin
    state_nxt = state;
    if (timeout) begin
      state_nxt = ST_IDLE;
    end else if (fall) begin
      unique case (state)
        ST_IDLE:   if (!fdata) state_nxt = ST_DATA;
        ST_DATA:   if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        ST_PARITY: state_nxt = ST_STOP;
        ST_STOP:   state_nxt = ST_IDLE;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: datapath enables and end-of-frame result.
  always_comb begin
    start_en  = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    byte_done = 1'b0;
    frame_err = timeout;
    if (fall && !timeout) begin
      unique case (state)
        ST_IDLE:   start_en = ~fdata;
        ST_DATA:   shift_en = 1'b1;
        ST_PARITY: par_en   = 1'b1;
        ST_STOP: begin
          byte_done = fdata & par_ok;
          frame_err = ~(fdata & par_ok);
        end
        default: ;
      endcase
    end
  end

  // Bit counter, shift register, parity bit and inactivity timer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (start_en) bit_cnt <= '0;
      if (shift_en) begin
        bit_cnt <= bit_cnt + 3'd1;
        shreg   <= {fdata, shreg[7:1]};
      end
      if (par_en) par_bit <= fdata;
      if (fall || timeout || state == ST_IDLE) tmo_cnt <= '0;
      else                                     tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  // Pipeline stage between frame capture and decode.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      byte_q  <= '0;
    end else begin
      valid_q <= byte_done;
      err_q   <= frame_err;
      if (byte_done) byte_q <= shreg;
    end
  end

  // Prefix/pause decode and key event outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      skip       <= '0;
      strobe_r   <= 1'b0;
      error_r    <= 1'b0;
      pressed_r  <= 1'b0;
      extended_r <= 1'b0;
      code_r     <= '0;
    end else begin
      strobe_r <= 1'b0;
      error_r  <= 1'b0;
      if (err_q) begin
        error_r <= 1'b1;
        ext     <= 1'b0;
        brk     <= 1'b0;
        skip    <= '0;
      end else if (valid_q) begin
        if (skip != 3'd0) begin
          skip <= skip - 3'd1;
        end else if (byte_q == CODE_E1) begin
          skip <= 3'd7;
        end else if (byte_q == CODE_E0) begin
          ext <= 1'b1;
        end else if (byte_q == CODE_F0) begin
          brk <= 1'b1;
        end else if (!(is_non_key(byte_q) && !ext && !brk)) begin
          code_r     <= byte_q;
          pressed_r  <= ~brk;
          extended_r <= ext;
          strobe_r   <= 1'b1;
          ext        <= 1'b0;
          brk        <= 1'b0;
        end
      end
    end
  end

  assign key.key_strobe   = strobe_r;
  assign key.rx_error     = error_r;
  assign key.key_pressed  = pressed_r;
  assign key.key_extended = extended_r;
  assign key.key_code     = code_r;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Scoreboard bench for ps2_key_rx: directed PS/2 frames, monitor checks events.
module tb_ps2_key_rx;

  localparam int unsigned FILTER_LEN = 4;
  localparam int unsigned TIMEOUT    = 200;
  localparam int HALF    = 20;
  localparam int LATENCY = FILTER_LEN + 4;

  typedef struct {
    logic       err;
    logic [7:0] code;
    logic       pressed;
    logic       ext;
    logic       chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_stop_cyc = 0;
  exp_t exp_q[$];

  logic [7:0] held_code = 8'h00;
  logic       held_pressed = 1'b0;
  logic       held_ext = 1'b0;

  ps2_key_rx_if key_if ();

  ps2_key_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ps2_clk_i(ps2_clk),
    .ps2_data_i(ps2_data),
    .key(key_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_key(input logic [7:0] code, input logic pressed, input logic ext);
    exp_t e;
    e.err = 1'b0; e.code = code; e.pressed = pressed; e.ext = ext; e.chk_lat = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic expect_err(input logic chk_lat);
    exp_t e;
    e.err = 1'b1; e.code = 8'h00; e.pressed = 1'b0; e.ext = 1'b0; e.chk_lat = chk_lat;
    exp_q.push_back(e);
  endtask

  // One PS/2 bit: data set while clock high, clock low for HALF cycles.
  task automatic ps2_bit(input logic b, input logic is_stop);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    if (is_stop) last_stop_cyc = cyc;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], 1'b0);
    ps2_bit((~^b) ^ par_flip, 1'b0);
    ps2_bit(stop, 1'b1);
    @(negedge clk) ps2_data = 1'b1;
    repeat (30) @(negedge clk);
  endtask

  task automatic send_ok(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1);
  endtask

  task automatic chk_held(input string tag);
    chk({tag, "_code"}, 32'(key_if.key_code), 32'(held_code));
    chk({tag, "_pressed"}, 32'(key_if.key_pressed), 32'(held_pressed));
    chk({tag, "_ext"}, 32'(key_if.key_extended), 32'(held_ext));
    chk({tag, "_strobe"}, 32'(key_if.key_strobe), 32'd0);
    chk({tag, "_err"}, 32'(key_if.rx_error), 32'd0);
  endtask

  // Monitor: every output event is matched against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n && (key_if.key_strobe || key_if.rx_error)) begin
        chk("exclusive", 32'(key_if.key_strobe & key_if.rx_error), 32'd0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_event: got strobe=%0b err=%0b code=%0h want none",
                   key_if.key_strobe, key_if.rx_error, key_if.key_code);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind_err", 32'(key_if.rx_error), 32'(e.err));
          if (e.chk_lat) chk("latency", 32'(cyc - last_stop_cyc), 32'(LATENCY));
          if (!e.err) begin
            chk("key_code", 32'(key_if.key_code), 32'(e.code));
            chk("key_pressed", 32'(key_if.key_pressed), 32'(e.pressed));
            chk("key_extended", 32'(key_if.key_extended), 32'(e.ext));
            held_code = e.code;
            held_pressed = e.pressed;
            held_ext = e.ext;
          end else begin
            chk("err_hold_code", 32'(key_if.key_code), 32'(held_code));
            chk("err_hold_pressed", 32'(key_if.key_pressed), 32'(held_pressed));
            chk("err_hold_ext", 32'(key_if.key_extended), 32'(held_ext));
          end
        end
      end
    end
  end

  initial begin
    repeat (5) @(negedge clk);
    chk_held("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (30) @(negedge clk);

    // Plain make code.
    expect_key(8'h1C, 1'b1, 1'b0);
    send_ok(8'h1C);

    // Extended break.
    send_ok(8'hE0);
    send_ok(8'hF0);
    expect_key(8'h75, 1'b0, 1'b1);
    send_ok(8'h75);

    // Non-extended break.
    send_ok(8'hF0);
    expect_key(8'h1C, 1'b0, 1'b0);
    send_ok(8'h1C);

    // Parity error, then recovery.
    expect_err(1'b1);
    send_frame(8'h1C, 1'b1, 1'b1);
    expect_key(8'h1C, 1'b1, 1'b0);
    send_ok(8'h1C);

    // Stop-bit error, with a pending E0 that must be cleared.
    send_ok(8'hE0);
    expect_err(1'b1);
    send_frame(8'h5A, 1'b0, 1'b0);
    expect_key(8'h5A, 1'b1, 1'b0);
    send_ok(8'h5A);

    // Non-key byte ignored.
    send_ok(8'hAA);
    send_ok(8'hFA);
    expect_key(8'h1C, 1'b1, 1'b0);
    send_ok(8'h1C);

    // Timeout: start bit plus 4 data bits, then the clock stays high.
    expect_err(1'b0);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1, 1'b0);
    @(negedge clk) ps2_data = 1'b1;
    repeat (TIMEOUT + 60) @(negedge clk);
    chk("timeout_seen", 32'(exp_q.size()), 32'd0);
    expect_key(8'h1C, 1'b1, 1'b0);
    send_ok(8'h1C);

    // Clock glitch one sample short of the filter length, data low.
    @(negedge clk) ps2_data = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (FILTER_LEN - 1) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_data = 1'b1;
    repeat (TIMEOUT + 60) @(negedge clk);
    chk_held("glitch");
    expect_key(8'h1C, 1'b1, 1'b0);
    send_ok(8'h1C);

    // Pause key sequence is swallowed entirely.
    send_ok(8'hE1); send_ok(8'h14); send_ok(8'h77); send_ok(8'hE1);
    send_ok(8'hF0); send_ok(8'h14); send_ok(8'hF0); send_ok(8'h77);
    expect_key(8'h1C, 1'b1, 1'b0);
    send_ok(8'h1C);

    // Reset in the middle of a frame.
    ps2_bit(1'b0, 1'b0);
    ps2_bit(1'b1, 1'b0);
    ps2_bit(1'b0, 1'b0);
    @(negedge clk) ps2_data = 1'b1;
    reset_n = 1'b0;
    repeat (4) @(negedge clk);
    held_code = 8'h00;
    held_pressed = 1'b0;
    held_ext = 1'b0;
    chk_held("midreset");
    reset_n = 1'b1;
    repeat (TIMEOUT + 60) @(negedge clk);
    expect_key(8'h1C, 1'b1, 1'b0);
    send_ok(8'h1C);

    repeat (50) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
